led_event_blinker: RTL and testbench
====================================

// Module: led_event_blinker
// PURPOSE
//   Output-side human interface, the counterpart of the input debouncer.
//   Turns single-cycle internal events into human-visible LED blinks:
//   each event produces one blink of fixed ON time, followed by a fixed OFF gap.
//   Events arriving during a blink are queued in a saturating counter.
//   Sits between core logic (event sources) and the board LED pin.
// PARAMETERS
//   ON_TIME   75000  LED lit cycles per event; 1 <= ON_TIME < 2**CNT_W
//   OFF_TIME  75000  dark gap cycles after each blink; 1 <= OFF_TIME < 2**CNT_W
//   CNT_W     17     width of the ON/OFF countdown timer
//   PEND_W    4      width of the pending-event counter
//   PWM_W     4      width of the PWM counter and i_duty (used only with LED_PWM_EN)
// PORTS
//   i_clk       in   1       system clock
//   i_reset     in   1       synchronous active-high reset
//   i_event     in   1       event strobe; each high cycle counts as one event
//   i_duty      in   PWM_W   ON-phase brightness (ignored without LED_PWM_EN)
//   o_led       out  1       registered LED drive
//   o_busy      out  1       high whenever state != IDLE
//   o_pending   out  PEND_W  queued events not yet started
//   o_overflow  out  1       sticky: an event was lost at pending saturation
// BEHAVIOUR
//   Reset:
//   - All outputs 0, state IDLE, timer 0, pending 0, PWM counter 0.
//   - Reset mid-blink aborts it: o_led, o_busy, o_pending are 0 the next cycle.
//   Pending counter:
//   - +1 per i_event cycle; -1 when a blink starts.
//   - Increment and start in the same cycle: net unchanged.
//   - Increment at 2**PEND_W-1 with no simultaneous start: count stays,
//     o_overflow<=1. o_overflow clears only on reset.
//   States:
//   - IDLE: if pending!=0 -> ON, timer<=ON_TIME-1, pending-1.
//     Pending is read from its register, so an event in cycle 0 raises o_led
//     in cycle 2. This 2-cycle latency is fixed.
//   - ON: o_led=1 for exactly ON_TIME cycles.
//     timer!=0: decrement. timer==0: -> OFF, timer<=OFF_TIME-1.
//   - OFF: o_led=0 for exactly OFF_TIME cycles.
//     timer==0: pending!=0 -> ON (reload, pending-1); else -> IDLE.
//   - Back-to-back blink period is exactly ON_TIME+OFF_TIME; there is no IDLE
//     cycle between queued blinks.
//   Outputs:
//   - o_busy = (state != IDLE), from a state register.
//   - o_pending is the registered count.
// CONFIGURATION
//   LED_PWM_EN defined:
//   - A free-running PWM_W counter (reset 0) dims the ON phase:
//     o_led = (pwm_cnt < i_duty) || (&i_duty), i.e. all-ones duty = fully on.
//     OFF/IDLE phases stay 0.
//   - ON/OFF timing and pending behaviour are unchanged.
//   LED_PWM_EN undefined:
//   - No PWM counter; i_duty ignored; o_led=1 for the whole ON phase.
// TESTING  (ON_TIME=4, OFF_TIME=3, PEND_W=2, PWM_W=2 unless noted)
//   1 Single i_event in cycle 0 -> o_led=1 cycles 2-5, 0 cycles 6-8;
//     o_busy=1 cycles 2-8, 0 from cycle 9; o_pending=1 in cycle 1 only.
//   2 i_event in cycles 0,1,2 -> o_led high 2-5, 9-12, 16-19;
//     o_pending peaks at 2; o_overflow stays 0.
//   3 i_event held high cycles 0-5 -> o_pending saturates at 3;
//     o_overflow=1 and stays 1 after the queue drains; exactly 4 blinks total
//     (1 started + 3 queued).
//   4 Event in cycle 0, i_reset in cycle 3 (mid-ON) -> cycle 4: o_led=0,
//     o_busy=0, o_pending=0; a later event blinks with normal 2-cycle latency.
//   5 i_event in the final OFF cycle of a blink, pending=1 -> next blink starts
//     immediately; o_pending stays 1 (simultaneous +1/-1).
//   6 LED_PWM_EN, single event: i_duty=1 -> o_led high 1 of every 4 ON cycles;
//     i_duty=3 -> o_led high all 4 ON cycles; without macro, o_led high all
//     4 regardless of i_duty.

Source files
------------

// File: rtl/led_event_blinker.sv
// Event-to-blink LED driver: one fixed ON/OFF blink per event, extra events queued.
// Optional LED_PWM_EN dims the ON phase with a free-running PWM counter.
module led_event_blinker #(
   parameter int ON_TIME  = 75000,
   parameter int OFF_TIME = 75000,
   parameter int CNT_W    = 17,
   parameter int PEND_W   = 4,
   parameter int PWM_W    = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_event,
   input  logic [PWM_W-1:0]  i_duty,
   output logic              o_led,
   output logic              o_busy,
   output logic [PEND_W-1:0] o_pending,
   output logic              o_overflow
);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_timer, w_timer_nxt;
   logic [PEND_W-1:0]  r_pend;
   logic               r_ovf;
   logic               r_led, w_led_nxt;
   logic               w_start;
   logic               w_pwm_on;

`ifdef LED_PWM_EN
   logic [PWM_W-1:0]   r_pwm;
   logic [PWM_W-1:0]   w_pwm_nxt;

   // LED is registered, so compare against the count it will show with
   assign w_pwm_nxt = r_pwm + 1'b1;
   assign w_pwm_on  = (w_pwm_nxt < i_duty) || (&i_duty);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_pwm <= '0;
      else         r_pwm <= w_pwm_nxt;
   end
`else
   logic w_unused_duty;
   assign w_unused_duty = ^i_duty;
   assign w_pwm_on      = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_led   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_led   <= w_led_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: if (r_pend != '0) begin
            w_state_nxt = S_ON;
            w_timer_nxt = CNT_W'(ON_TIME - 1);
            w_start     = 1'b1;
         end
         S_ON: if (r_timer != '0) begin
            w_timer_nxt = r_timer - 1'b1;
         end else begin
            w_state_nxt = S_OFF;
            w_timer_nxt = CNT_W'(OFF_TIME - 1);
         end
         S_OFF: if (r_timer != '0) begin
            w_timer_nxt = r_timer - 1'b1;
         end else if (r_pend != '0) begin
            w_state_nxt = S_ON;
            w_timer_nxt = CNT_W'(ON_TIME - 1);
            w_start     = 1'b1;
         end else begin
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_led_nxt = (w_state_nxt == S_ON) && w_pwm_on;
   end

   // Simultaneous event and blink start cancel out
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pend <= '0;
         r_ovf  <= 1'b0;
      end else begin
         case ({i_event, w_start})
            2'b10: if (&r_pend) r_ovf <= 1'b1;
                   else         r_pend <= r_pend + 1'b1;
            2'b01: r_pend <= r_pend - 1'b1;
            default: ;
         endcase
      end
   end

   assign o_led      = r_led;
   assign o_busy     = (r_state != S_IDLE);
   assign o_pending  = r_pend;
   assign o_overflow = r_ovf;

endmodule

// File: tb/tb_led_event_blinker.sv
// Directed bench for led_event_blinker with ON_TIME=4, OFF_TIME=3, PEND_W=2, PWM_W=2.
module tb_led_event_blinker;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_event = 1'b0;
   logic [1:0] i_duty = 2'b11;
   logic       o_led, o_busy, o_overflow;
   logic [1:0] o_pending;

   int checks = 0;
   int failures = 0;

   led_event_blinker #(.ON_TIME(4), .OFF_TIME(3), .CNT_W(17), .PEND_W(2), .PWM_W(2)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_event(i_event), .i_duty(i_duty),
      .o_led(o_led), .o_busy(o_busy), .o_pending(o_pending), .o_overflow(o_overflow)
   );

   always #5 i_clk = ~i_clk;

   // Leaves the bench at posedge+1 of cycle 0 with the DUT idle
   task automatic do_reset();
      i_reset = 1'b1;
      i_event = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      i_event = 1'b1;
      @(posedge i_clk); #1;
      @(negedge i_clk);
      checks++;
      if ({o_led, o_busy, o_pending, o_overflow} !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=00000", {o_led, o_busy, o_pending, o_overflow});
      end
      do_reset();
   endtask

   task automatic test_single();
      logic [63:0] exp_led, exp_busy;
      logic [1:0]  exp_pend;
      exp_led  = 64'h3C;
      exp_busy = 64'h1FC;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         i_event = (c == 0);
         @(negedge i_clk);
         exp_pend = (c == 1) ? 2'd1 : 2'd0;
         checks++;
         if (o_led !== exp_led[c]) begin
            failures++; $display("FAIL single_led c=%0d got=%b exp=%b", c, o_led, exp_led[c]);
         end
         checks++;
         if (o_busy !== exp_busy[c]) begin
            failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, o_busy, exp_busy[c]);
         end
         checks++;
         if (o_pending !== exp_pend) begin
            failures++; $display("FAIL single_pend c=%0d got=%0d exp=%0d", c, o_pending, exp_pend);
         end
         @(posedge i_clk); #1;
      end
      i_event = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_led, exp_busy;
      logic [1:0]  exp_pend;
      int          peak;
      exp_led  = 64'hF1E3C;
      exp_busy = 64'h7FFFFC;
      peak = 0;
      do_reset();
      for (int c = 0; c < 26; c++) begin
         i_event = (c <= 2);
         @(negedge i_clk);
         if (c == 0)      exp_pend = 2'd0;
         else if (c < 3)  exp_pend = 2'd1;
         else if (c < 9)  exp_pend = 2'd2;
         else if (c < 16) exp_pend = 2'd1;
         else             exp_pend = 2'd0;
         if (int'(o_pending) > peak) peak = int'(o_pending);
         checks++;
         if (o_led !== exp_led[c]) begin
            failures++; $display("FAIL b2b_led c=%0d got=%b exp=%b", c, o_led, exp_led[c]);
         end
         checks++;
         if (o_busy !== exp_busy[c]) begin
            failures++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, o_busy, exp_busy[c]);
         end
         checks++;
         if (o_pending !== exp_pend) begin
            failures++; $display("FAIL b2b_pend c=%0d got=%0d exp=%0d", c, o_pending, exp_pend);
         end
         checks++;
         if (o_overflow !== 1'b0) begin
            failures++; $display("FAIL b2b_ovf c=%0d got=%b exp=0", c, o_overflow);
         end
         @(posedge i_clk); #1;
      end
      i_event = 1'b0;
      checks++;
      if (peak != 2) begin
         failures++; $display("FAIL b2b_peak got=%0d exp=2", peak);
      end
   endtask

   task automatic test_overflow();
      logic [63:0] exp_led, exp_busy;
      logic [1:0]  exp_pend;
      logic        exp_ovf, prev_led;
      int          blinks;
      exp_led  = 64'h78F1E3C;
      exp_busy = 64'h3FFFFFFC;
      blinks = 0;
      prev_led = 1'b0;
      do_reset();
      for (int c = 0; c < 34; c++) begin
         i_event = (c <= 5);
         @(negedge i_clk);
         if (c == 0)      exp_pend = 2'd0;
         else if (c < 3)  exp_pend = 2'd1;
         else if (c == 3) exp_pend = 2'd2;
         else if (c < 9)  exp_pend = 2'd3;
         else if (c < 16) exp_pend = 2'd2;
         else if (c < 23) exp_pend = 2'd1;
         else             exp_pend = 2'd0;
         exp_ovf = (c >= 5);
         if (o_led && !prev_led) blinks++;
         prev_led = o_led;
         checks++;
         if (o_led !== exp_led[c]) begin
            failures++; $display("FAIL ovf_led c=%0d got=%b exp=%b", c, o_led, exp_led[c]);
         end
         checks++;
         if (o_busy !== exp_busy[c]) begin
            failures++; $display("FAIL ovf_busy c=%0d got=%b exp=%b", c, o_busy, exp_busy[c]);
         end
         checks++;
         if (o_pending !== exp_pend) begin
            failures++; $display("FAIL ovf_pend c=%0d got=%0d exp=%0d", c, o_pending, exp_pend);
         end
         checks++;
         if (o_overflow !== exp_ovf) begin
            failures++; $display("FAIL ovf_flag c=%0d got=%b exp=%b", c, o_overflow, exp_ovf);
         end
         @(posedge i_clk); #1;
      end
      i_event = 1'b0;
      checks++;
      if (blinks != 4) begin
         failures++; $display("FAIL ovf_blinks got=%0d exp=4", blinks);
      end
      do_reset();
      @(negedge i_clk);
      checks++;
      if (o_overflow !== 1'b0) begin
         failures++; $display("FAIL ovf_clear got=%b exp=0", o_overflow);
      end
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset_mid_blink();
      logic [63:0] exp_led;
      logic [1:0]  exp_pend;
      exp_led = 64'h30C;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         i_event = (c == 0) || (c == 6);
         i_reset = (c == 3);
         @(negedge i_clk);
         exp_pend = (c == 1 || c == 7) ? 2'd1 : 2'd0;
         checks++;
         if (o_led !== exp_led[c]) begin
            failures++; $display("FAIL midrst_led c=%0d got=%b exp=%b", c, o_led, exp_led[c]);
         end
         checks++;
         if (o_busy !== exp_led[c]) begin
            failures++; $display("FAIL midrst_busy c=%0d got=%b exp=%b", c, o_busy, exp_led[c]);
         end
         checks++;
         if (o_pending !== exp_pend) begin
            failures++; $display("FAIL midrst_pend c=%0d got=%0d exp=%0d", c, o_pending, exp_pend);
         end
         @(posedge i_clk); #1;
      end
      i_event = 1'b0;
      i_reset = 1'b0;
   endtask

   task automatic test_last_off_event();
      logic [63:0] exp_led;
      logic [1:0]  exp_pend;
      exp_led = 64'hF1E3C;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         i_event = (c == 0) || (c == 1) || (c == 8);
         @(negedge i_clk);
         exp_pend = (c >= 1 && c < 16) ? 2'd1 : 2'd0;
         checks++;
         if (o_led !== exp_led[c]) begin
            failures++; $display("FAIL lastoff_led c=%0d got=%b exp=%b", c, o_led, exp_led[c]);
         end
         checks++;
         if (o_pending !== exp_pend) begin
            failures++; $display("FAIL lastoff_pend c=%0d got=%0d exp=%0d", c, o_pending, exp_pend);
         end
         @(posedge i_clk); #1;
      end
      i_event = 1'b0;
   endtask

   task automatic test_duty();
      int on_cnt;
      int exp_cnt;
      for (int d = 0; d < 2; d++) begin
         i_duty = (d == 0) ? 2'd1 : 2'd3;
`ifdef LED_PWM_EN
         exp_cnt = (d == 0) ? 1 : 4;
`else
         exp_cnt = 4;
`endif
         on_cnt = 0;
         do_reset();
         for (int c = 0; c < 10; c++) begin
            i_event = (c == 0);
            @(negedge i_clk);
            if (o_led) begin
               if (c >= 2 && c <= 5) on_cnt++;
               else begin
                  checks++; failures++;
                  $display("FAIL duty_outside d=%0d c=%0d got=1 exp=0", i_duty, c);
               end
            end
            @(posedge i_clk); #1;
         end
         i_event = 1'b0;
         checks++;
         if (on_cnt != exp_cnt) begin
            failures++; $display("FAIL duty_on_cycles d=%0d got=%0d exp=%0d", i_duty, on_cnt, exp_cnt);
         end
      end
      i_duty = 2'b11;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid_blink();
      test_last_off_event();
      test_duty();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
